dtack_watchdog: RTL and testbench
=================================

# dtack_watchdog

Bus-cycle watchdog on the 68000 side, directly downstream of the TMSS stage. It merges the TMSS DTACK with the other DTACK sources (VDP, I/O, cartridge) into the single DTACK driven to the CPU. When no source answers within a fixed number of CPU clocks, it forces DTACK so the bus cannot hang. It also records the address of the last faulting cycle for debug.

## Interface
Parameters:
- TIMEOUT_CYC, 128, CPU clocks (CLK_EN pulses) allowed before a forced DTACK; legal range 2..2^CNT_W
- CNT_W, 8, width of the timeout counter and of fault_cnt

Ports:
- MCLK  in  1  master clock; all state changes on its rising edge
- SRES  in  1  synchronous reset, active-low; sampled on MCLK
- CLK_EN  in  1  one-MCLK pulse per 68k clock; the counter advances only on this pulse
- EN  in  1  watchdog enable; 0 means pure DTACK merge with no timeout
- AS  in  1  68k address strobe, active-low
- RW  in  1  68k read/write (1 = read)
- VA  in  23  68k word address
- DTACK_tmss  in  1  DTACK from the TMSS stage, active-low
- DTACK_ext  in  1  AND of all other DTACK sources, active-low
- DTACK  out  1  merged DTACK to the CPU, active-low
- TIMEOUT  out  1  one-MCLK pulse when a forced DTACK starts
- fault_addr  out  23  VA captured at the last timeout
- fault_rw  out  1  RW captured at the last timeout
- fault_cnt  out  CNT_W  number of timeouts, saturating

## Operation
- Source acknowledge: src_ack = ~DTACK_tmss | ~DTACK_ext.
- DTACK output: DTACK = ~(src_ack | force_q). This path is combinational from the sources with zero latency. force_q is registered.
- States and transitions:
  - IDLE
    - AS=0 & EN=1 → WAIT, with cnt=0.
    - AS=0 & EN=0 → ACK. This is a bypass; no counting takes place.
  - WAIT
    - AS=1 → IDLE. The cycle was aborted; cnt is cleared and nothing is recorded.
    - Otherwise, src_ack=1 → ACK, with cnt cleared.
    - Otherwise, CLK_EN=1 & cnt==TIMEOUT_CYC-1 → FORCED. On the same edge: force_q←1, TIMEOUT←1, fault_addr←VA, fault_rw←RW, and fault_cnt←fault_cnt+1, saturating at 2^CNT_W-1.
    - Otherwise, CLK_EN=1 → cnt←cnt+1.
  - ACK
    - Wait for AS=1, then → IDLE.
  - FORCED
    - Hold force_q=1 until AS=1, then → IDLE with force_q←0.
- Priority: src_ack on the same MCLK as the terminal count → ACK. No timeout is raised and no fault is recorded.
- EN falling while in WAIT: go to ACK and clear cnt. A cycle already in FORCED completes normally.
- TIMEOUT is high only on the single MCLK following the transition into FORCED.
- The watchdog samples AS and the sources directly on MCLK. It contains no synchronizers, because all inputs are MCLK-domain.

## Timing
- Reset (SRES=0 at an edge), applied in any state, including mid-cycle:
  - State and counters: state=IDLE, cnt=0, force_q=0.
  - Outputs: TIMEOUT=0, fault_addr=0, fault_rw=0, fault_cnt=0.
  - DTACK still follows the sources combinationally, so it equals 1 when both sources are high.
- Timeout latency: AS falls at edge E0. The forced DTACK appears on the MCLK edge of the TIMEOUT_CYC-th CLK_EN pulse after E0, counting pulses at or after E0+1.
- Release: force_q clears on the first MCLK edge that samples AS=1. DTACK is therefore high one MCLK after AS rises (when the sources are high).
- Back-to-back cycles: AS=0 sampled in IDLE starts a new count immediately, with no dead cycle.
- fault_* registers hold their values until the next timeout or reset.

## Test plan
- Normal merge: with EN=1, DTACK_tmss pulls low at CLK_EN #3 after AS falls → DTACK low in the same MCLK; no TIMEOUT; fault_cnt=0.
- Timeout: EN=1, TIMEOUT_CYC=128, VA=23'h50A080, RW=0, sources held high → TIMEOUT pulse and DTACK=0 at CLK_EN #128; fault_addr=23'h50A080, fault_rw=0, fault_cnt=1. AS rise → DTACK=1 one MCLK later.
- Race at the terminal count: DTACK_ext goes low on the same MCLK as CLK_EN #128 → ACK path taken; TIMEOUT stays 0 and fault_cnt is unchanged.
- Abort and bypass:
  - AS rises at CLK_EN #50 → IDLE with no fault.
  - The next cycle counts from 0 (timeout at #128, not #78).
  - EN=0 with silent sources → DTACK stays 1 indefinitely and TIMEOUT=0.
- Saturation: CNT_W=8; force 260 timeouts → fault_cnt=255 stays at 255.
- Reset mid-FORCED: SRES=0 for one MCLK while force_q=1 → DTACK=1, fault_cnt=0 and state IDLE on the next edge. With AS still low after reset, a new WAIT count starts.

Source files
------------

// File: rtl/dtack_watchdog.sv
// Bus-cycle watchdog for the 68000: merges TMSS and external DTACK sources and
// forces DTACK when no source answers within TIMEOUT_CYC CPU clocks.
module dtack_watchdog #(
   parameter int TIMEOUT_CYC = 128,
   parameter int CNT_W       = 8
) (
   input  logic             MCLK,
   input  logic             SRES,
   input  logic             CLK_EN,
   input  logic             EN,
   input  logic             AS,
   input  logic             RW,
   input  logic [22:0]      VA,
   input  logic             DTACK_tmss,
   input  logic             DTACK_ext,
   output logic             DTACK,
   output logic             TIMEOUT,
   output logic [22:0]      fault_addr,
   output logic             fault_rw,
   output logic [CNT_W-1:0] fault_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_FORCED
   } state_t;

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             force_q, force_d;
   logic             timeout_q, timeout_d;
   logic [22:0]      fault_addr_q, fault_addr_d;
   logic             fault_rw_q, fault_rw_d;
   logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
   logic             src_ack;

   // Sources are MCLK-domain, so the merge is purely combinational: zero added latency.
   assign src_ack = ~DTACK_tmss | ~DTACK_ext;
   assign DTACK   = ~(src_ack | force_q);

   assign TIMEOUT    = timeout_q;
   assign fault_addr = fault_addr_q;
   assign fault_rw   = fault_rw_q;
   assign fault_cnt  = fault_cnt_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; that is what keeps this block free of inferred latches.
      state_d      = state_q;
      cnt_d        = cnt_q;
      force_d      = force_q;
      timeout_d    = 1'b0;
      fault_addr_d = fault_addr_q;
      fault_rw_d   = fault_rw_q;
      fault_cnt_d  = fault_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (!AS) begin
               cnt_d   = '0;
               state_d = EN ? S_WAIT : S_ACK;
            end
         end

         S_WAIT: begin
            if (AS) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (src_ack || !EN) begin
               // A real acknowledge wins over a terminal count on the same edge.
               state_d = S_ACK;
               cnt_d   = '0;
            end else if (CLK_EN) begin
               if (cnt_q == TERM_CNT) begin
                  state_d      = S_FORCED;
                  cnt_d        = '0;
                  force_d      = 1'b1;
                  timeout_d    = 1'b1;
                  fault_addr_d = VA;
                  fault_rw_d   = RW;
                  if (fault_cnt_q != CNT_MAX) begin
                     fault_cnt_d = fault_cnt_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_ACK: begin
            if (AS) begin
               state_d = S_IDLE;
            end
         end

         S_FORCED: begin
            if (AS) begin
               state_d = S_IDLE;
               force_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            force_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge MCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!SRES) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         force_q      <= 1'b0;
         timeout_q    <= 1'b0;
         fault_addr_q <= '0;
         fault_rw_q   <= 1'b0;
         fault_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         force_q      <= force_d;
         timeout_q    <= timeout_d;
         fault_addr_q <= fault_addr_d;
         fault_rw_q   <= fault_rw_d;
         fault_cnt_q  <= fault_cnt_d;
      end
   end

endmodule

// File: tb/tb_dtack_watchdog.sv
// Directed bench for dtack_watchdog: merge, timeout, terminal-count race,
// abort, bypass, EN drop, saturation and reset while forced.
module tb_dtack_watchdog;

   localparam int TIMEOUT_CYC = 128;
   localparam int CNT_W       = 8;

   logic             MCLK = 1'b0;
   logic             SRES;
   logic             CLK_EN;
   logic             EN;
   logic             AS;
   logic             RW;
   logic [22:0]      VA;
   logic             DTACK_tmss;
   logic             DTACK_ext;
   logic             DTACK;
   logic             TIMEOUT;
   logic [22:0]      fault_addr;
   logic             fault_rw;
   logic [CNT_W-1:0] fault_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int to_seen  = 0;
   int to_mark;

   dtack_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .MCLK       (MCLK),
      .SRES       (SRES),
      .CLK_EN     (CLK_EN),
      .EN         (EN),
      .AS         (AS),
      .RW         (RW),
      .VA         (VA),
      .DTACK_tmss (DTACK_tmss),
      .DTACK_ext  (DTACK_ext),
      .DTACK      (DTACK),
      .TIMEOUT    (TIMEOUT),
      .fault_addr (fault_addr),
      .fault_rw   (fault_rw),
      .fault_cnt  (fault_cnt)
   );

   always #5 MCLK = ~MCLK;

   // Count MCLK periods with TIMEOUT high, sampled mid-period.
   always @(negedge MCLK) begin
      if (TIMEOUT === 1'b1) to_seen++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running need finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One MCLK edge; returns at the following falling edge.
   task automatic tick();
      @(posedge MCLK);
      @(negedge MCLK);
   endtask

   // n CPU clocks, each a one-MCLK CLK_EN pulse followed by an idle MCLK.
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         CLK_EN = 1'b1;
         tick();
         CLK_EN = 1'b0;
         tick();
      end
   endtask

   // A full timed-out bus cycle with CLK_EN held high, then release.
   task automatic fast_timeout();
      AS = 1'b0;
      tick();
      CLK_EN = 1'b1;
      repeat (TIMEOUT_CYC) tick();
      CLK_EN = 1'b0;
      AS = 1'b1;
      tick();
   endtask

   initial begin
      SRES = 1'b0; CLK_EN = 1'b0; EN = 1'b1; AS = 1'b1; RW = 1'b1;
      VA = '0; DTACK_tmss = 1'b1; DTACK_ext = 1'b1;
      @(negedge MCLK);
      tick();
      tick();

      // Reset state
      check("rst_dtack", DTACK, 1);
      check("rst_timeout", TIMEOUT, 0);
      check("rst_fault_addr", fault_addr, 0);
      check("rst_fault_rw", fault_rw, 0);
      check("rst_fault_cnt", fault_cnt, 0);
      DTACK_tmss = 1'b0;
      #1 check("rst_dtack_merge", DTACK, 0);
      DTACK_tmss = 1'b1;
      SRES = 1'b1;
      tick();

      // Normal merge: TMSS answers at CPU clock #3
      AS = 1'b0; VA = 23'h012345; RW = 1'b1;
      tick();
      pulses(2);
      CLK_EN = 1'b1; DTACK_tmss = 1'b0;
      #1 check("merge_dtack_comb", DTACK, 0);
      tick();
      CLK_EN = 1'b0;
      check("merge_timeout", TIMEOUT, 0);
      check("merge_dtack_held", DTACK, 0);
      AS = 1'b1; DTACK_tmss = 1'b1;
      #1 check("merge_release", DTACK, 1);
      tick();
      check("merge_fault_cnt", fault_cnt, 0);

      // Timeout at CPU clock #128
      AS = 1'b0; VA = 23'h50A080; RW = 1'b0;
      tick();
      pulses(TIMEOUT_CYC - 1);
      check("to_before_term_dtack", DTACK, 1);
      check("to_before_term_timeout", TIMEOUT, 0);
      CLK_EN = 1'b1;
      tick();
      CLK_EN = 1'b0;
      check("to_pulse", TIMEOUT, 1);
      check("to_dtack", DTACK, 0);
      check("to_fault_addr", fault_addr, 23'h50A080);
      check("to_fault_rw", fault_rw, 0);
      check("to_fault_cnt", fault_cnt, 1);
      VA = 23'h7FFFFF; RW = 1'b1;
      tick();
      check("to_pulse_end", TIMEOUT, 0);
      check("to_dtack_held", DTACK, 0);
      AS = 1'b1;
      #1 check("to_dtack_until_edge", DTACK, 0);
      tick();
      check("to_release", DTACK, 1);
      check("to_fault_addr_hold", fault_addr, 23'h50A080);

      // Race: external source answers on the terminal CPU clock
      AS = 1'b0; VA = 23'h001111; RW = 1'b1;
      to_mark = to_seen;
      tick();
      pulses(TIMEOUT_CYC - 1);
      CLK_EN = 1'b1; DTACK_ext = 1'b0;
      tick();
      CLK_EN = 1'b0;
      check("race_timeout", TIMEOUT, 0);
      check("race_dtack", DTACK, 0);
      DTACK_ext = 1'b1;
      #1 check("race_no_force", DTACK, 1);
      pulses(4);
      check("race_timeouts_seen", to_seen - to_mark, 0);
      check("race_fault_cnt", fault_cnt, 1);
      check("race_fault_addr", fault_addr, 23'h50A080);
      AS = 1'b1;
      tick();

      // Abort at CPU clock #50, then a fresh count
      AS = 1'b0; VA = 23'h022222;
      to_mark = to_seen;
      tick();
      pulses(49);
      CLK_EN = 1'b1; AS = 1'b1;
      tick();
      CLK_EN = 1'b0;
      tick();
      check("abort_timeouts_seen", to_seen - to_mark, 0);
      check("abort_fault_cnt", fault_cnt, 1);
      AS = 1'b0; VA = 23'h033333; RW = 1'b1;
      tick();
      pulses(78);
      check("recount_78_dtack", DTACK, 1);
      pulses(49);
      check("recount_127_dtack", DTACK, 1);
      check("recount_127_seen", to_seen - to_mark, 0);
      CLK_EN = 1'b1;
      tick();
      CLK_EN = 1'b0;
      check("recount_timeout", TIMEOUT, 1);
      check("recount_fault_addr", fault_addr, 23'h033333);
      check("recount_fault_rw", fault_rw, 1);
      check("recount_fault_cnt", fault_cnt, 2);
      AS = 1'b1;
      tick();

      // Bypass: EN=0, silent sources
      EN = 1'b0; AS = 1'b0;
      to_mark = to_seen;
      tick();
      pulses(200);
      check("bypass_dtack", DTACK, 1);
      check("bypass_timeouts_seen", to_seen - to_mark, 0);
      AS = 1'b1;
      tick();
      EN = 1'b1;

      // EN dropped while waiting: cycle completes without a timeout
      AS = 1'b0;
      tick();
      pulses(10);
      EN = 1'b0;
      tick();
      EN = 1'b1;
      pulses(200);
      check("endrop_dtack", DTACK, 1);
      check("endrop_timeouts_seen", to_seen - to_mark, 0);
      check("endrop_fault_cnt", fault_cnt, 2);
      AS = 1'b1;
      tick();

      // Saturation of fault_cnt
      to_mark = to_seen;
      for (int i = 0; i < 253; i++) fast_timeout();
      check("sat_reach", fault_cnt, 255);
      for (int i = 0; i < 7; i++) fast_timeout();
      check("sat_hold", fault_cnt, 255);
      check("sat_pulses", to_seen - to_mark, 260);

      // Reset while forced, AS still low afterwards
      AS = 1'b0; VA = 23'h044444; RW = 1'b0;
      tick();
      CLK_EN = 1'b1;
      repeat (TIMEOUT_CYC) tick();
      CLK_EN = 1'b0;
      check("rf_forced", DTACK, 0);
      SRES = 1'b0;
      tick();
      SRES = 1'b1;
      check("rf_dtack", DTACK, 1);
      check("rf_fault_cnt", fault_cnt, 0);
      check("rf_fault_addr", fault_addr, 0);
      check("rf_timeout", TIMEOUT, 0);
      VA = 23'h055555;
      tick();
      pulses(TIMEOUT_CYC - 1);
      check("rf_recount_dtack", DTACK, 1);
      CLK_EN = 1'b1;
      tick();
      CLK_EN = 1'b0;
      check("rf_recount_timeout", TIMEOUT, 1);
      check("rf_recount_fault_cnt", fault_cnt, 1);
      check("rf_recount_fault_addr", fault_addr, 23'h055555);
      AS = 1'b1;
      tick();
      check("rf_final_release", DTACK, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
